// File: rtl/vblank_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vblank_ram_arbiter
// Description : Starts a game step every TICK_FRAMES frames at the top of
//               vertical blanking and hands the single-port board RAM to the
//               game-update engine until it finishes or blanking ends.
// Revision    : 1.0  initial release
// ============================================================================
module vblank_ram_arbiter #(
  parameter int ADDR_W      = 11,
  parameter int DATA_W      = 4,
  parameter int TICK_FRAMES = 8,
  parameter int V_VISIBLE   = 480,
  parameter int V_TOTAL     = 525
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        px,
  input  logic [9:0]        py,
  input  logic [ADDR_W-1:0] ren_addr,
  output logic [DATA_W-1:0] ren_rdata,
  output logic              step_start,
  input  logic              step_done,
  input  logic              upd_req,
  input  logic              upd_we,
  input  logic [ADDR_W-1:0] upd_addr,
  input  logic [DATA_W-1:0] upd_wdata,
  output logic              upd_gnt,
  output logic              upd_rvalid,
  output logic [DATA_W-1:0] upd_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              overrun,
  output logic [15:0]       step_count
);

  localparam logic [9:0] c_frame_line = 10'(V_VISIBLE);
  localparam logic [9:0] c_close_line = 10'(V_TOTAL - 1);
  localparam logic [7:0] c_tick_last  = 8'(TICK_FRAMES - 1);

  typedef enum logic [1:0] {
    S_RENDER = 2'd0,
    S_START  = 2'd1,
    S_UPDATE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_fcnt;
  logic [7:0]  w_fcnt_nxt;
  logic        r_overrun;
  logic        w_overrun_nxt;
  logic [15:0] r_step_count;
  logic [15:0] w_step_count_nxt;
  logic        r_upd_rvalid;

  logic        w_frame_edge;
  logic        w_win_close;
  logic        w_owner;

  assign w_frame_edge = (px == 10'd0) && (py == c_frame_line);
  // The final line is kept as a guard so the renderer owns the RAM before line 0.
  assign w_win_close  = (px == 10'd0) && (py == c_close_line);
  assign w_owner      = (r_state == S_UPDATE);

  always_comb begin
    w_state_nxt      = r_state;
    w_fcnt_nxt       = r_fcnt;
    w_overrun_nxt    = r_overrun;
    w_step_count_nxt = r_step_count;
    case (r_state)
      S_RENDER: begin
        if (w_frame_edge) begin
          if (r_fcnt == c_tick_last) begin
            w_fcnt_nxt  = 8'd0;
            w_state_nxt = S_START;
          end else begin
            w_fcnt_nxt  = r_fcnt + 8'd1;
          end
        end
      end
      S_START: begin
        w_state_nxt = S_UPDATE;
      end
      S_UPDATE: begin
        // A done coinciding with window close still counts as a completion.
        if (step_done) begin
          w_state_nxt      = S_RENDER;
          w_step_count_nxt = r_step_count + 16'd1;
        end else if (w_win_close) begin
          w_state_nxt   = S_RENDER;
          w_overrun_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_RENDER;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_RENDER;
      r_fcnt       <= 8'd0;
      r_overrun    <= 1'b0;
      r_step_count <= 16'd0;
      r_upd_rvalid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_fcnt       <= w_fcnt_nxt;
      r_overrun    <= w_overrun_nxt;
      r_step_count <= w_step_count_nxt;
      r_upd_rvalid <= upd_gnt & ~upd_we;
    end
  end

  assign upd_gnt    = w_owner & upd_req;
  assign ram_addr   = w_owner ? upd_addr  : ren_addr;
  assign ram_we     = w_owner & upd_req & upd_we;
  assign ram_wdata  = w_owner ? upd_wdata : '0;

  assign step_start = (r_state == S_START);
  assign upd_rvalid = r_upd_rvalid;
  assign upd_rdata  = ram_rdata;
  assign ren_rdata  = ram_rdata;
  assign overrun    = r_overrun;
  assign step_count = r_step_count;

endmodule
`default_nettype wire

// File: tb/tb_vblank_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_vblank_ram_arbiter
// Description : Randomized bench for vblank_ram_arbiter with a compressed
//               raster (4 px per line) and an event-level reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_vblank_ram_arbiter;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 4;
  localparam int TICK   = 2;
  localparam int V_VIS  = 480;
  localparam int V_TOT  = 525;
  localparam int H_PX   = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [9:0]        px = 10'd0;
  logic [9:0]        py = 10'd100;
  logic [ADDR_W-1:0] ren_addr;
  logic [DATA_W-1:0] ren_rdata;
  logic              step_start;
  logic              step_done;
  logic              upd_req;
  logic              upd_we;
  logic [ADDR_W-1:0] upd_addr;
  logic [DATA_W-1:0] upd_wdata;
  logic              upd_gnt;
  logic              upd_rvalid;
  logic [DATA_W-1:0] upd_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              overrun;
  logic [15:0]       step_count;

  vblank_ram_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TICK_FRAMES(TICK),
    .V_VISIBLE(V_VIS), .V_TOTAL(V_TOT)
  ) dut (
    .clk(clk), .rst(rst), .px(px), .py(py),
    .ren_addr(ren_addr), .ren_rdata(ren_rdata),
    .step_start(step_start), .step_done(step_done),
    .upd_req(upd_req), .upd_we(upd_we), .upd_addr(upd_addr), .upd_wdata(upd_wdata),
    .upd_gnt(upd_gnt), .upd_rvalid(upd_rvalid), .upd_rdata(upd_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .overrun(overrun), .step_count(step_count)
  );

  always #5 clk = ~clk;

  // Board RAM: synchronous single port, read-before-write.
  logic [DATA_W-1:0] mem [1<<ADDR_W];
  always @(posedge clk) begin
    if (ram_we === 1'b1) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  // Compressed raster generator.
  always @(posedge clk) begin
    #1;
    if (px == 10'(H_PX - 1)) begin
      px = 10'd0;
      py = (py == 10'(V_TOT - 1)) ? 10'd0 : py + 10'd1;
    end else begin
      px = px + 10'd1;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: game step lifecycle tracked by cycle stamps.
  int                m_cyc       = 0;
  bit                m_valid     = 0;
  bit                m_busy      = 0;
  int                m_start_cyc = 0;
  int                m_edges     = 0;
  int                m_count     = 0;
  bit                m_over      = 0;
  bit                m_rv        = 0;
  logic [ADDR_W-1:0] m_rd_addr   = '0;
  logic [DATA_W-1:0] m_mem [1<<ADDR_W];
  int                n_starts    = 0;

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      mem[i]   = '0;
      m_mem[i] = '0;
    end
  end

  always @(negedge clk) begin
    bit owner;
    m_cyc++;
    owner = m_busy && (m_cyc > m_start_cyc);
    if (m_valid) begin
      check("step_start", 32'(step_start), 32'(m_busy && (m_cyc == m_start_cyc)));
      check("upd_gnt",    32'(upd_gnt),    32'(owner && upd_req));
      check("ram_we",     32'(ram_we),     32'(owner && upd_req && upd_we));
      check("ram_addr",   32'(ram_addr),   32'(owner ? upd_addr : ren_addr));
      check("ram_wdata",  32'(ram_wdata),  32'(owner ? upd_wdata : 4'd0));
      check("upd_rvalid", 32'(upd_rvalid), 32'(m_rv));
      check("overrun",    32'(overrun),    32'(m_over));
      check("step_count", 32'(step_count), 32'(m_count[15:0]));
      check("ren_rdata",  32'(ren_rdata),  32'(ram_rdata));
      if (m_rv) check("upd_rdata", 32'(upd_rdata), 32'(m_mem[m_rd_addr]));
    end
    if (step_start === 1'b1) n_starts++;
    if (m_valid) begin
      if (owner && upd_req && upd_we) m_mem[upd_addr] = upd_wdata;
      m_rv      = owner && upd_req && !upd_we;
      m_rd_addr = upd_addr;
      if (owner) begin
        if (step_done) begin
          m_busy  = 0;
          m_count = m_count + 1;
        end else if (px == 10'd0 && py == 10'(V_TOT - 1)) begin
          m_busy = 0;
          m_over = 1;
        end
      end else if (!m_busy && px == 10'd0 && py == 10'(V_VIS)) begin
        m_edges++;
        if (m_edges == TICK) begin
          m_edges     = 0;
          m_busy      = 1;
          m_start_cyc = m_cyc + 1;
        end
      end
    end
    if (rst === 1'b1) begin
      m_valid = 1;
      m_busy  = 0;
      m_edges = 0;
      m_count = 0;
      m_over  = 0;
      m_rv    = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic rand_upd();
    upd_req   = 1'($urandom_range(0, 1));
    upd_we    = 1'($urandom_range(0, 1));
    upd_addr  = 11'($urandom_range(0, 15));
    upd_wdata = 4'($urandom);
    ren_addr  = 11'($urandom);
  endtask

  // Runs random traffic until step_start; returns frame edges seen on the way.
  task automatic wait_start(output int edges);
    bit ok = 0;
    edges = 0;
    for (int n = 0; n < 6000 && !ok; n++) begin
      tick();
      rand_upd();
      if (px == 10'd0 && py == 10'(V_VIS)) edges++;
      if (step_start === 1'b1) ok = 1;
    end
    if (!ok) check("start_timeout", 32'd0, 32'd1);
  endtask

  // Advances until the window-close position is being presented.
  task automatic run_to_close(input bit random_traffic);
    bit ok = 0;
    for (int n = 0; n < 1000 && !ok; n++) begin
      tick();
      if (random_traffic) rand_upd();
      else begin
        upd_req = 1'b1;
        upd_we  = 1'b0;
      end
      if (px == 10'd0 && py == 10'(V_TOT - 1)) ok = 1;
    end
    if (!ok) check("close_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int edges;
    int starts0;
    rst       = 1'b1;
    step_done = 1'b0;
    upd_req   = 1'b1;
    upd_we    = 1'b1;
    upd_addr  = '0;
    upd_wdata = '0;
    ren_addr  = 11'h123;

    // Reset mid-frame
    repeat (3) tick();
    check("rst_overrun",    32'(overrun),    32'd0);
    check("rst_step_count", 32'(step_count), 32'd0);
    check("rst_rvalid",     32'(upd_rvalid), 32'd0);
    check("rst_step_start", 32'(step_start), 32'd0);
    check("rst_ram_we",     32'(ram_we),     32'd0);
    check("rst_upd_gnt",    32'(upd_gnt),    32'd0);
    check("rst_ram_addr",   32'(ram_addr),   32'h123);
    rst = 1'b0;

    // Tick cadence over four frames, done 10 cycles after each start
    starts0 = n_starts;
    for (int s = 0; s < 2; s++) begin
      wait_start(edges);
      check("cad_edges",    32'(edges), 32'd2);
      check("cad_start_py", 32'(py),    32'd480);
      check("cad_start_px", 32'(px),    32'd1);
      for (int k = 1; k <= 10; k++) begin
        tick();
        rand_upd();
        step_done = (k == 10);
      end
      tick();
      step_done = 1'b0;
    end
    check("cad_starts",     32'(n_starts - starts0), 32'd2);
    check("cad_step_count", 32'(step_count),         32'd2);

    // Write then read back inside UPDATE
    wait_start(edges);
    tick();
    upd_req = 1'b1; upd_we = 1'b1; upd_addr = 11'd5; upd_wdata = 4'hA;
    tick();
    upd_req = 1'b1; upd_we = 1'b0; upd_addr = 11'd5;
    tick();
    upd_req = 1'b0;
    check("rd_rvalid", 32'(upd_rvalid), 32'd1);
    check("rd_rdata",  32'(upd_rdata),  32'hA);
    step_done = 1'b1;
    tick();
    step_done = 1'b0;
    check("wr_step_count", 32'(step_count), 32'd3);

    // Done in the same cycle as window close
    wait_start(edges);
    run_to_close(1'b1);
    step_done = 1'b1;
    tick();
    step_done = 1'b0;
    check("sim_overrun",    32'(overrun),    32'd0);
    check("sim_step_count", 32'(step_count), 32'd4);

    // Overrun: never signal done
    wait_start(edges);
    run_to_close(1'b0);
    check("ovr_gnt_close", 32'(upd_gnt), 32'd1);
    tick();
    check("ovr_gnt_after",   32'(upd_gnt),    32'd0);
    check("ovr_overrun",     32'(overrun),    32'd1);
    check("ovr_step_count",  32'(step_count), 32'd4);
    wait_start(edges);
    check("ovr_next_edges", 32'(edges),   32'd2);
    check("ovr_sticky",     32'(overrun), 32'd1);
    for (int k = 1; k <= 5; k++) begin
      tick();
      rand_upd();
      step_done = (k == 5);
    end
    tick();
    step_done = 1'b0;
    check("ovr_step_count2", 32'(step_count), 32'd5);

    // Reset while a write is being presented
    wait_start(edges);
    tick();
    upd_req = 1'b1; upd_we = 1'b1; upd_addr = 11'd7; upd_wdata = 4'h3;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rw_ram_we",     32'(ram_we),     32'd0);
    check("rw_upd_gnt",    32'(upd_gnt),    32'd0);
    check("rw_step_count", 32'(step_count), 32'd0);
    check("rw_overrun",    32'(overrun),    32'd0);
    wait_start(edges);
    check("rw_edges", 32'(edges), 32'd2);
    tick();
    upd_req = 1'b1; upd_we = 1'b0; upd_addr = 11'd7;
    tick();
    upd_req = 1'b0;
    step_done = 1'b1;
    check("rw_rdata", 32'(upd_rdata), 32'h3);
    tick();
    step_done = 1'b0;
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
